// File: rtl/sbox_fwd_subword.sv
// Serial forward AES S-box unit: one 32-bit word in, optional RotWord, four bytes substituted
// one per cycle through a single bit-level S-box netlist. Optional macro: SBOX_FWD_PIPE_EN.
module sbox_fwd_subword (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] in_data,
    input  logic        rot_en,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_data
);

    typedef enum logic [1:0] {IDLE, SUB, DONE} state_t;

    // Top-linear-layer signals that the nonlinear middle layer consumes; d is input bit u7.
    typedef struct packed {
        logic d,   t1,  t2,  t3,  t4,  t6,  t8,  t9,  t10, t13, t14;
        logic t15, t16, t17, t19, t20, t22, t23, t24, t25, t26, t27;
    } top_t;

    function automatic top_t sbox_top(input logic [7:0] b);
        logic [0:7]  u;
        logic [1:27] t;
        top_t        r;
        // NOTE: blocking assignments are correct here; function locals are evaluated in order.
        u     = b;
        t[1]  = u[0] ^ u[3];   t[2]  = u[0] ^ u[5];   t[3]  = u[0] ^ u[6];
        t[4]  = u[3] ^ u[5];   t[5]  = u[4] ^ u[6];   t[6]  = t[1] ^ t[5];
        t[7]  = u[1] ^ u[2];   t[8]  = u[7] ^ t[6];   t[9]  = u[7] ^ t[7];
        t[10] = t[6] ^ t[7];   t[11] = u[1] ^ u[5];   t[12] = u[2] ^ u[5];
        t[13] = t[3] ^ t[4];   t[14] = t[6] ^ t[11];  t[15] = t[5] ^ t[11];
        t[16] = t[5] ^ t[12];  t[17] = t[9] ^ t[16];  t[18] = u[3] ^ u[7];
        t[19] = t[7] ^ t[18];  t[20] = t[1] ^ t[19];  t[21] = u[6] ^ u[7];
        t[22] = t[7] ^ t[21];  t[23] = t[2] ^ t[22];  t[24] = t[2] ^ t[10];
        t[25] = t[20] ^ t[17]; t[26] = t[3] ^ t[16];  t[27] = t[1] ^ t[12];
        r = '{d: u[7], t1: t[1], t2: t[2], t3: t[3], t4: t[4], t6: t[6], t8: t[8],
              t9: t[9], t10: t[10], t13: t[13], t14: t[14], t15: t[15], t16: t[16],
              t17: t[17], t19: t[19], t20: t[20], t22: t[22], t23: t[23], t24: t[24],
              t25: t[25], t26: t[26], t27: t[27]};
        return r;
    endfunction

    function automatic logic [7:0] sbox_bottom(input top_t t);
        logic [1:63] m;
        logic [0:29] l;
        logic [0:7]  s;
        m[1]  = t.t13 & t.t6;   m[2]  = t.t23 & t.t8;   m[3]  = t.t14 ^ m[1];
        m[4]  = t.t19 & t.d;    m[5]  = m[4] ^ m[1];    m[6]  = t.t3 & t.t16;
        m[7]  = t.t22 & t.t9;   m[8]  = t.t26 ^ m[6];   m[9]  = t.t20 & t.t17;
        m[10] = m[9] ^ m[6];    m[11] = t.t1 & t.t15;   m[12] = t.t4 & t.t27;
        m[13] = m[12] ^ m[11];  m[14] = t.t2 & t.t10;   m[15] = m[14] ^ m[11];
        m[16] = m[3] ^ m[2];    m[17] = m[5] ^ t.t24;   m[18] = m[8] ^ m[7];
        m[19] = m[10] ^ m[15];  m[20] = m[16] ^ m[13];  m[21] = m[17] ^ m[15];
        m[22] = m[18] ^ m[13];  m[23] = m[19] ^ t.t25;
        // GF(2^4) inversion core
        m[24] = m[22] ^ m[23];  m[25] = m[22] & m[20];  m[26] = m[21] ^ m[25];
        m[27] = m[20] ^ m[21];  m[28] = m[23] ^ m[25];  m[29] = m[28] & m[27];
        m[30] = m[26] & m[24];  m[31] = m[20] & m[23];  m[32] = m[27] & m[31];
        m[33] = m[27] ^ m[25];  m[34] = m[21] & m[22];  m[35] = m[24] & m[34];
        m[36] = m[24] ^ m[25];  m[37] = m[21] ^ m[29];  m[38] = m[32] ^ m[33];
        m[39] = m[23] ^ m[30];  m[40] = m[35] ^ m[36];  m[41] = m[38] ^ m[40];
        m[42] = m[37] ^ m[39];  m[43] = m[37] ^ m[38];  m[44] = m[39] ^ m[40];
        m[45] = m[42] ^ m[41];
        m[46] = m[44] & t.t6;   m[47] = m[40] & t.t8;   m[48] = m[39] & t.d;
        m[49] = m[43] & t.t16;  m[50] = m[38] & t.t9;   m[51] = m[37] & t.t17;
        m[52] = m[42] & t.t15;  m[53] = m[45] & t.t27;  m[54] = m[41] & t.t10;
        m[55] = m[44] & t.t13;  m[56] = m[40] & t.t23;  m[57] = m[39] & t.t19;
        m[58] = m[43] & t.t3;   m[59] = m[38] & t.t22;  m[60] = m[37] & t.t20;
        m[61] = m[42] & t.t1;   m[62] = m[45] & t.t4;   m[63] = m[41] & t.t2;
        // bottom linear layer, affine constant folded into the XNORs
        l[0]  = m[61] ^ m[62];  l[1]  = m[50] ^ m[56];  l[2]  = m[46] ^ m[48];
        l[3]  = m[47] ^ m[55];  l[4]  = m[54] ^ m[58];  l[5]  = m[49] ^ m[61];
        l[6]  = m[62] ^ l[5];   l[7]  = m[46] ^ l[3];   l[8]  = m[51] ^ m[59];
        l[9]  = m[52] ^ m[53];  l[10] = m[53] ^ l[4];   l[11] = m[60] ^ l[2];
        l[12] = m[48] ^ m[51];  l[13] = m[50] ^ l[0];   l[14] = m[52] ^ m[61];
        l[15] = m[55] ^ l[1];   l[16] = m[56] ^ l[0];   l[17] = m[57] ^ l[1];
        l[18] = m[58] ^ l[8];   l[19] = m[63] ^ l[4];   l[20] = l[0] ^ l[1];
        l[21] = l[1] ^ l[7];    l[22] = l[3] ^ l[12];   l[23] = l[18] ^ l[2];
        l[24] = l[15] ^ l[9];   l[25] = l[6] ^ l[10];   l[26] = l[7] ^ l[9];
        l[27] = l[8] ^ l[10];   l[28] = l[11] ^ l[14];  l[29] = l[11] ^ l[17];
        s[0] = l[6] ^ l[24];    s[1] = ~(l[16] ^ l[26]);
        s[2] = ~(l[19] ^ l[28]); s[3] = l[6] ^ l[21];
        s[4] = l[20] ^ l[22];   s[5] = l[25] ^ l[29];
        s[6] = ~(l[13] ^ l[27]); s[7] = ~(l[6] ^ l[23]);
        return s;
    endfunction

    state_t      state;
    logic [1:0]  idx;
    logic [31:0] word_reg;
    logic [31:0] result_reg;
    logic [31:0] result_next;
    logic [7:0]  sbox_in;
    logic [7:0]  sbox_out;
    logic [1:0]  wr_slot;
    logic        wr_en;
    top_t        top_lin;

    always_comb begin
        case (idx)
            2'd0:    sbox_in = word_reg[31:24];
            2'd1:    sbox_in = word_reg[23:16];
            2'd2:    sbox_in = word_reg[15:8];
            default: sbox_in = word_reg[7:0];
        endcase
    end

    assign top_lin = sbox_top(sbox_in);

`ifdef SBOX_FWD_PIPE_EN
    top_t       top_q;
    logic       stage_valid;
    logic [1:0] stage_slot;
    logic       issue_done;

    // NOTE: pure datapath stage with no reset; stage_valid qualifies its contents.
    always_ff @(posedge clk) begin
        top_q <= top_lin;
    end

    assign sbox_out = sbox_bottom(top_q);
    assign wr_slot  = stage_slot;
    assign wr_en    = (state == SUB) && stage_valid;
`else
    assign sbox_out = sbox_bottom(top_lin);
    assign wr_slot  = idx;
    assign wr_en    = (state == SUB);
`endif

    always_comb begin
        result_next = result_reg;
        case (wr_slot)
            2'd0:    result_next[31:24] = sbox_out;
            2'd1:    result_next[23:16] = sbox_out;
            2'd2:    result_next[15:8]  = sbox_out;
            default: result_next[7:0]   = sbox_out;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state      <= IDLE;
            idx        <= 2'd0;
            word_reg   <= 32'h0;
            result_reg <= 32'h0;
`ifdef SBOX_FWD_PIPE_EN
            stage_valid <= 1'b0;
            stage_slot  <= 2'd0;
            issue_done  <= 1'b0;
`endif
        end else begin
            if (wr_en) result_reg <= result_next;
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        word_reg <= rot_en ? {in_data[23:0], in_data[31:24]} : in_data;
                        idx      <= 2'd0;
                        state    <= SUB;
`ifdef SBOX_FWD_PIPE_EN
                        stage_valid <= 1'b0;
                        issue_done  <= 1'b0;
`endif
                    end
                end
                SUB: begin
`ifdef SBOX_FWD_PIPE_EN
                    if (!issue_done) begin
                        idx        <= idx + 2'd1;
                        issue_done <= (idx == 2'd3);
                    end
                    stage_valid <= !issue_done;
                    stage_slot  <= idx;
                    if (stage_valid && stage_slot == 2'd3) state <= DONE;
`else
                    idx <= idx + 2'd1;
                    if (idx == 2'd3) state <= DONE;
`endif
                end
                DONE: begin
                    if (out_ready) state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign in_ready  = (state == IDLE);
    assign out_valid = (state == DONE);
    assign out_data  = result_reg;

endmodule

// File: tb/tb_sbox_fwd_subword.sv
// Scoreboard bench for sbox_fwd_subword; reference S-box built from GF(2^8) inversion + affine map.
module tb_sbox_fwd_subword;

`ifdef SBOX_FWD_PIPE_EN
    localparam int LAT = 5;
    localparam int THRU = 7;
    localparam int RST_WAIT = 3;
`else
    localparam int LAT = 4;
    localparam int THRU = 6;
    localparam int RST_WAIT = 2;
`endif

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [31:0] in_data = 32'h0;
    logic        rot_en = 1'b0;
    logic        out_valid;
    logic        out_ready = 1'b1;
    logic [31:0] out_data;

    sbox_fwd_subword dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .in_data(in_data), .rot_en(rot_en), .out_valid(out_valid),
        .out_ready(out_ready), .out_data(out_data)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] exp;
        logic [31:0] src;
        int          acc;
    } exp_t;

    exp_t       q[$];
    logic [7:0] sbox_tab[256];
    logic [7:0] inv_tab[256];
    int         cyc = 0;
    int         checks = 0;
    int         failures = 0;
    int         last_acc = 0;
    bit         bp_en = 1'b0;
    bit         seen = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p = 8'h0;
        logic [7:0] x = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p ^= x;
            x = x[7] ? ((x << 1) ^ 8'h1b) : (x << 1);
        end
        return p;
    endfunction

    function automatic logic [7:0] rotl8(input logic [7:0] x, input int n);
        return (x << n) | (x >> (8 - n));
    endfunction

    function automatic logic [31:0] sub_word(input logic [31:0] w);
        return {sbox_tab[w[31:24]], sbox_tab[w[23:16]], sbox_tab[w[15:8]], sbox_tab[w[7:0]]};
    endfunction

    initial begin
        for (int b = 0; b < 256; b++) begin
            logic [7:0] inv = 8'h0;
            for (int x = 1; x < 256; x++)
                if (gf_mul(8'(b), 8'(x)) == 8'h01) inv = 8'(x);
            sbox_tab[b] = inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 8'h63;
        end
        for (int b = 0; b < 256; b++) inv_tab[sbox_tab[b]] = 8'(b);
    end

    // Random output backpressure, applied well clear of both clock edges.
    always begin
        @(posedge clk);
        #1;
        if (bp_en) out_ready = 1'($urandom_range(0, 1));
    end

    // Monitor: checks latency on first out_valid, data and round trip on each output handshake.
    always @(negedge clk) begin
        exp_t e;
        logic [31:0] rt;
        if (!rst_n) begin
            seen = 1'b0;
        end else if (out_valid) begin
            if (q.size() == 0) begin
                check("unexpected_output", {31'h0, out_valid}, 32'h0);
            end else begin
                if (!seen) begin
                    seen = 1'b1;
                    check("latency", 32'(cyc - q[0].acc), 32'(LAT));
                end
                if (out_ready) begin
                    e = q.pop_front();
                    check("out_data", out_data, e.exp);
                    rt = {inv_tab[out_data[31:24]], inv_tab[out_data[23:16]],
                          inv_tab[out_data[15:8]], inv_tab[out_data[7:0]]};
                    check("inverse_round_trip", rt, e.src);
                    seen = 1'b0;
                end
            end
        end
    end

    // Called just after a negedge; returns just after the negedge following the input handshake.
    task automatic send(input logic [31:0] d, input logic r, input bit push);
        int n = 0;
        exp_t e;
        in_data  = d;
        rot_en   = r;
        in_valid = 1'b1;
        while (!in_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (!in_ready) begin
            check("in_ready_timeout", {31'h0, in_ready}, 32'h1);
            return;
        end
        e.src = r ? {d[23:0], d[31:24]} : d;
        e.exp = sub_word(e.src);
        e.acc = cyc + 1;
        last_acc = e.acc;
        if (push) q.push_back(e);
        @(negedge clk);
    endtask

    task automatic wait_drain();
        int n = 0;
        while (q.size() != 0 && n < 300) begin
            @(negedge clk);
            n++;
        end
        check("drain", 32'(q.size()), 32'h0);
    endtask

    initial begin
        int prev;
        int n;
        repeat (3) @(negedge clk);
        check("reset_in_ready", {31'h0, in_ready}, 32'h1);
        check("reset_out_valid", {31'h0, out_valid}, 32'h0);
        check("reset_out_data", out_data, 32'h0);
        rst_n = 1'b1;
        @(negedge clk);

        send(32'h00010253, 1'b0, 1'b1);
        in_valid = 1'b0;
        wait_drain();
        check("vec0_ref", sub_word(32'h00010253), 32'h637c77ed);

        send(32'h09cf4f3c, 1'b1, 1'b1);
        in_valid = 1'b0;
        wait_drain();

        // Output stall: result must hold and a waiting input must not be taken.
        out_ready = 1'b0;
        send(32'hffffffff, 1'b0, 1'b1);
        in_data = 32'h5a5a5a5a;
        n = 0;
        while (!out_valid && n < 20) begin
            @(negedge clk);
            n++;
        end
        check("stall_out_valid_rise", {31'h0, out_valid}, 32'h1);
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            check("stall_out_valid", {31'h0, out_valid}, 32'h1);
            check("stall_out_data", out_data, 32'h16161616);
            check("stall_in_ready", {31'h0, in_ready}, 32'h0);
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        wait_drain();

        // Abort mid-word with reset; the word must vanish without output.
        send(32'h12345678, 1'b0, 1'b0);
        in_valid = 1'b0;
        repeat (RST_WAIT - 1) @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        check("abort_out_valid", {31'h0, out_valid}, 32'h0);
        check("abort_out_data", out_data, 32'h0);
        check("abort_in_ready", {31'h0, in_ready}, 32'h1);
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            check("abort_no_output", {31'h0, out_valid}, 32'h0);
        end

        // Random words, random rot_en, random output backpressure and input gaps.
        bp_en = 1'b1;
        for (int i = 0; i < 24; i++) begin
            send($urandom, 1'($urandom_range(0, 1)), 1'b1);
            in_valid = 1'b0;
            repeat ($urandom_range(0, 2)) @(negedge clk);
        end
        wait_drain();
        bp_en = 1'b0;
        @(negedge clk);
        out_ready = 1'b1;

        // Back-to-back sweep of every byte value.
        for (int b = 0; b < 256; b++) begin
            prev = last_acc;
            send({4{8'(b)}}, 1'b0, 1'b1);
            if (b > 0) check("throughput", 32'(last_acc - prev), 32'(THRU));
        end
        in_valid = 1'b0;
        wait_drain();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/sbox_fwd_subword.md
# sbox_fwd_subword

Serial forward AES S-box unit: accepts one 32-bit word over a valid/ready handshake, optionally applies RotWord, and substitutes its four bytes one per cycle through a single forward S-box datapath before returning the result over a second valid/ready handshake. It is the encryption-direction counterpart of the inverse S-box: same bit-level XOR/XNOR/AND gate style, same bit convention (u0/w0 = byte MSB). It serves the key-expansion SubWord/RotWord step and any 32-bit datapath that needs forward substitution with one S-box instance.

## Interface
- No parameters.
- clk  in  1  system clock, all state updates on rising edge
- rst_n  in  1  synchronous, active-low reset
- in_valid  in  1  input word present
- in_ready  out  1  unit idle and able to accept a word
- in_data  in  32  input word; [31:24] = AES byte a0, [7:0] = a3
- rot_en  in  1  sampled with in_data; 1 = apply RotWord before substitution
- out_valid  out  1  result available
- out_ready  in  1  consumer accepts result
- out_data  out  32  substituted word, same byte order as in_data

## Operation
- Forward S-box: combinational gate netlist, inputs u0..u7 = byte bit7..bit0, outputs w0..w7 = bit7..bit0; registered instance under the configuration macro below.
- FSM states: IDLE, SUB, DONE.
- IDLE: in_ready=1. On in_valid & in_ready: load word register with in_data, or {in_data[23:0], in_data[31:24]} when rot_en=1; idx<=0; go to SUB.
- SUB: S-box input is the word-register byte selected by idx (idx 0 = [31:24], 3 = [7:0]); each S-box result is written into the same byte slot of the result register. When the last byte is written, go to DONE. in_ready=0; in_valid is ignored.
- DONE: out_valid=1, out_data = result register, held stable until out_ready=1. On out_valid & out_ready: go to IDLE.
- No bypass: a new word is never accepted in the same cycle a result is consumed.
- Reset (rst_n=0 at a rising edge) from any state, mid-operation included: state IDLE, idx 0, word and result registers 0, out_valid 0, out_data 0. The in-flight word is discarded and produces no output.
- Reset values: in_ready=1 (IDLE decode), out_valid=0, out_data=32'h0.

## Timing
- E0 = edge at which the input handshake fires.
- Without the macro: byte k is written at edge E(k+1); state goes to DONE at E4. out_valid is high in the cycle after E4, so latency is 4 cycles.
- With the macro: byte k is written at E(k+2); DONE at E5; latency 5 cycles.
- E1 = edge at which the output handshake fires. in_ready is high in the cycle after E1. Sustained throughput is one word per 6 cycles (7 with the macro) when out_ready is held at 1.
- out_ready held low: out_valid and out_data are held indefinitely.
- in_valid held high while busy: no additional word is loaded.

## Configuration
- SBOX_FWD_PIPE_EN defined: a register stage sits between the S-box top linear layer and the nonlinear middle layer. idx and the write slot are delayed one cycle to match, and the S-box input for byte k+1 is presented while byte k is in the second stage. Latency is 5 cycles; timing closure is improved.
- Not defined: the S-box is purely combinational between the word register and the result register. Latency is 4 cycles.
- Handshake semantics and results are identical in both builds.

## Test plan
- Reset, then in_data=32'h00010253, rot_en=0 -> out_data=32'h637c77ed; out_valid rises exactly 4 cycles after accept (5 with the macro).
- in_data=32'h09cf4f3c, rot_en=1 (FIPS-197 key expansion, w[3]) -> out_data=32'h8a84eb01.
- in_data=32'hffffffff, rot_en=0 -> 32'h16161616. Then hold out_ready=0 for 10 cycles -> out_valid and out_data remain stable and in_ready remains 0.
- Drive rst_n=0 for 1 cycle during SUB after 2 bytes have been processed -> out_valid=0, out_data=0, in_ready=1 on the next cycle; no output is produced for the aborted word.
- 256 back-to-back words {b,b,b,b} for b=0..255, with out_ready=1 and in_valid=1 -> each byte of every result matches the FIPS-197 forward S-box. Inverse-S-box round trip returns b. One word completes every 6 cycles (7 with the macro).
